// File: rtl/playback_sequencer.sv
// playback_sequencer: steps through up to 16 stored notes, sounding each as a square wave.
// Latency: per note 1 (LOAD) + RD_LAT (WAIT_RD) + NOTE_TICKS (PLAY) + GAP_TICKS (GAP) clocks.
// Backpressure: none; start is ignored while busy, stop aborts to IDLE on the next edge.
//
// Ports:
//   clk, reset        - clock (rising edge), synchronous active-low reset
//   start, stop       - one-cycle playback request / abort
//   note_count        - number of stored notes (0..16, larger values clamp to 16)
//   freq_in           - half-period in clocks of the addressed note, 0 = rest
//   note_counter      - memory read address
//   ld_play           - high from LOAD through GAP
//   next_note_en      - one-cycle pulse per note load
//   busy, done        - not-IDLE flag / normal-completion pulse
//   audio_out         - square-wave tone
//
// Optional feature: define PLAYBACK_LOOP_EN to loop back to note 0 after the last
// note instead of finishing; only stop or reset then end playback.
module playback_sequencer #(
  parameter int unsigned NOTE_TICKS = 12500000,
  parameter int unsigned GAP_TICKS  = 1250000,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [4:0]  note_count,
  input  logic [31:0] freq_in,
  output logic [3:0]  note_counter,
  output logic        ld_play,
  output logic        next_note_en,
  output logic        busy,
  output logic        done,
  output logic        audio_out
);

  // A zero length would never match the terminal count, so it is stretched to one cycle.
  localparam logic [31:0] NOTE_LEN  = (NOTE_TICKS == 0) ? 32'd1 : 32'(NOTE_TICKS);
  localparam logic [31:0] GAP_LEN   = (GAP_TICKS == 0)  ? 32'd1 : 32'(GAP_TICKS);
  localparam logic [31:0] RD_LEN    = (RD_LAT == 0)     ? 32'd1 : 32'(RD_LAT);
  localparam logic [31:0] NOTE_LAST = NOTE_LEN - 32'd1;
  localparam logic [31:0] GAP_LAST  = GAP_LEN - 32'd1;
  localparam logic [31:0] RD_LAST   = RD_LEN - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_RD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  nc_q, nc_d;
  logic [31:0] tick_q, tick_d;
  logic [31:0] tone_q, tone_d;
  logic [31:0] freq_q, freq_d;
  logic        audio_q, audio_d;

  logic [4:0]  nc_eff;
  logic        last_note;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      nc_q    <= 4'd0;
      tick_q  <= 32'd0;
      tone_q  <= 32'd0;
      freq_q  <= 32'd0;
      audio_q <= 1'b0;
    end else begin
      state_q <= state_d;
      nc_q    <= nc_d;
      tick_q  <= tick_d;
      tone_q  <= tone_d;
      freq_q  <= freq_d;
      audio_q <= audio_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    nc_d         = nc_q;
    tick_d       = tick_q;
    tone_d       = 32'd0;
    freq_d       = freq_q;
    audio_d      = 1'b0;
    ld_play      = 1'b0;
    next_note_en = 1'b0;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;

    nc_eff    = (note_count > 5'd16) ? 5'd16 : note_count;
    // Compare as count+1 >= N so a note_count that drops to 0 mid-play ends cleanly.
    last_note = (({1'b0, nc_q} + 5'd1) >= nc_eff);

    case (state_q)
      S_IDLE: begin
        if (start && (nc_eff != 5'd0)) begin
          state_d = S_LOAD;
          nc_d    = 4'd0;
          tick_d  = 32'd0;
        end
      end

      S_LOAD: begin
        ld_play      = 1'b1;
        next_note_en = 1'b1;
        tick_d       = 32'd0;
        state_d      = S_WAIT_RD;
      end

      S_WAIT_RD: begin
        ld_play = 1'b1;
        if (tick_q == RD_LAST) begin
          freq_d  = freq_in;
          tick_d  = 32'd0;
          state_d = S_PLAY;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end

      S_PLAY: begin
        ld_play = 1'b1;
        audio_d = audio_q;
        if (freq_q != 32'd0) begin
          if (tone_q == (freq_q - 32'd1)) begin
            tone_d  = 32'd0;
            audio_d = ~audio_q;
          end else begin
            tone_d = tone_q + 32'd1;
          end
        end
        if (tick_q == NOTE_LAST) begin
          tick_d  = 32'd0;
          tone_d  = 32'd0;
          audio_d = 1'b0;
          state_d = S_GAP;
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end

      S_GAP: begin
        ld_play = 1'b1;
        if (tick_q == GAP_LAST) begin
          tick_d = 32'd0;
          if (!last_note) begin
            nc_d    = nc_q + 4'd1;
            state_d = S_LOAD;
          end else begin
`ifdef PLAYBACK_LOOP_EN
            nc_d    = 4'd0;
            state_d = S_LOAD;
`else
            state_d = S_DONE;
`endif
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort has priority over every transition above; note_counter keeps its value.
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tick_d  = 32'd0;
      tone_d  = 32'd0;
      audio_d = 1'b0;
    end
  end

  assign note_counter = nc_q;
  assign audio_out    = audio_q;

endmodule

// File: doc/playback_sequencer.md
PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 SHALL have parameter NOTE_TICKS, 12500000, clocks each note sounds (0.25 s at 50 MHz).
REQ-002 SHALL have parameter GAP_TICKS, 1250000, silent clocks between notes.
REQ-003 SHALL have parameter RD_LAT, 2, clocks from note_counter change to valid freq_in (address register plus registered memory output).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to begin playback from address 0.
REQ-007 SHALL have port stop  input  1  one-cycle request to abort playback.
REQ-008 SHALL have port note_count  input  5  number of stored notes, 0..16; values above 16 are treated as 16.
REQ-009 SHALL have port freq_in  input  32  half-period in clocks of the current note; 0 = rest.
REQ-010 SHALL have port note_counter  output  4  memory read address driven to the datapath.
REQ-011 SHALL have port ld_play  output  1  high for the whole playback (states LOAD through GAP).
REQ-012 SHALL have port next_note_en  output  1  one-cycle pulse per note load, used to trigger the highlight redraw.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when playback ends normally.
REQ-015 SHALL have port audio_out  output  1  square-wave tone output.

Function
REQ-016 SHALL implement states IDLE, LOAD, WAIT_RD, PLAY, GAP and DONE.
REQ-017 IDLE SHALL move to LOAD with note_counter=0 when start=1 and effective note_count>0; start with note_count=0 SHALL be ignored.
REQ-018 LOAD SHALL last exactly 1 cycle, assert next_note_en, and go to WAIT_RD.
REQ-019 WAIT_RD SHALL last RD_LAT cycles, then capture freq_in into an internal register and go to PLAY.
REQ-020 PLAY SHALL last NOTE_TICKS cycles and then go to GAP.
REQ-021 During PLAY, the tone counter SHALL restart at 0, and audio_out SHALL toggle each time the counter reaches captured_freq-1.
REQ-022 audio_out SHALL be held at 0 when captured_freq=0, and in every state other than PLAY.
REQ-023 GAP SHALL last GAP_TICKS cycles; if note_counter<note_count-1 it SHALL increment note_counter and go to LOAD, otherwise it SHALL go to DONE.
REQ-024 DONE SHALL last 1 cycle, assert done, and return to IDLE.
REQ-025 note_counter SHALL hold its last value in IDLE.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 stop in any non-IDLE state SHALL force IDLE on the next edge, with audio_out=0, ld_play=0, and no done pulse.
REQ-028 When start and stop are asserted in the same cycle in IDLE, start SHALL win; when both are asserted while busy, stop SHALL win.
REQ-029 Tick counters SHALL be 32 bits wide; a NOTE_TICKS or GAP_TICKS value of 0 SHALL be treated as 1.

Reset
REQ-030 When reset=0 at a clock edge, the block SHALL enter IDLE.
REQ-031 Reset SHALL clear note_counter, ld_play, next_note_en, busy, done, audio_out and all counters to 0.
REQ-032 Reset SHALL override start and stop, including mid-note.

Configuration
REQ-033 When macro PLAYBACK_LOOP_EN is defined, GAP on the last note SHALL wrap note_counter to 0 and go to LOAD, DONE SHALL never be entered, and only stop or reset SHALL end playback.
REQ-034 When PLAYBACK_LOOP_EN is undefined, the block SHALL behave as in REQ-023 and REQ-024.

Verification (NOTE_TICKS=8, GAP_TICKS=2, RD_LAT=2)
REQ-035 Stimulus: note_count=3, freq_in=2, start pulse -> required: note_counter sequence 0,1,2; 3 next_note_en pulses 13 cycles apart; audio_out toggles every 2 clocks during PLAY; done pulse 1 cycle after the last GAP; busy=0 afterwards.
REQ-036 Stimulus: note_count=0, start pulse -> required: state stays IDLE; busy, ld_play and done stay 0.
REQ-037 Stimulus: note_count=2, freq_in=0 -> required: audio_out stays 0 throughout; timing is identical to a non-rest note.
REQ-038 Stimulus: stop pulse mid-PLAY of note 1 -> required: on the next cycle busy=0, ld_play=0, audio_out=0; no done pulse; note_counter=1.
REQ-039 Stimulus: reset=0 mid-GAP -> required: all outputs 0 on the next cycle; a following start replays from address 0.
REQ-040 Stimulus (PLAYBACK_LOOP_EN defined): note_count=16 -> required: note_counter wraps 15 to 0 with no done pulse; ld_play stays high until stop.
